mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Iterative MIPS MULT/MULTU/DIV/DIVU engine in the EX stage, directly upstream of the HI/LO generator.
//  Produces the 64-bit {hi,lo} value and a one-cycle done pulse that the HI/LO generator writes into HI/LO.
//  Requests a pipeline stall while an operation is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand width; must equal width of `DATA_BUS; result is 2*DATA_WIDTH (`DOUBLE_DATA_BUS)
// PORTS
//  clk              in   1    clock, rising edge
//  rst_n            in   1    asynchronous, active-low reset
//  start            in   1    EX holds a mult/div instruction this cycle
//  funct            in   `FUNCT_BUS  `FUNCT_MULT/`FUNCT_MULTU/`FUNCT_DIV/`FUNCT_DIVU; others ignored
//  operand_1        in   `DATA_BUS   rs: multiplicand / dividend
//  operand_2        in   `DATA_BUS   rt: multiplier / divisor
//  flush            in   1    exception/flush; abort current operation
//  stall_req        out  1    hold pipeline; combinational
//  mult_div_done    out  1    one-cycle pulse; result valid this cycle
//  mult_div_result  out  `DOUBLE_DATA_BUS  mult: [63:0] product; div: [63:32] remainder, [31:0] quotient
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, counter 0, mult_div_done 0, mult_div_result 0, stall_req 0.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: accept when start=1, funct is one of the four ops, flush=0.
//    On accept: latch |op1|,|op2| for signed ops, plus the result-sign and remainder-sign flags.
//    Go to BUSY; counter = 0.
//  - BUSY: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//    Leave BUSY after counter reaches 31 (32 cycles) -> DONE.
//  - DONE: register sign-corrected result.
//    mult_div_done=1 for exactly this cycle, then IDLE.
//  Latency: done asserted in the 33rd cycle after the accepting edge (i.e. T+33).
//  stall_req = (IDLE & accept condition) | BUSY; low in DONE, so the instruction advances with done.
//  Signed rules:
//  - product sign = s1^s2.
//  - quotient sign = s1^s2.
//  - remainder takes the sign of the dividend.
//  - negation is two's complement on full width.
//  Divide by zero (op2==0): skip BUSY, DONE next cycle; quotient=0xFFFFFFFF, remainder=op1 (raw, no sign fix).
//  DIV 0x80000000 / -1: quotient=0x80000000, remainder=0 (no trap).
//  start while BUSY/DONE: ignored (no queueing).
//  flush: any state -> IDLE at next edge.
//  - no done pulse, result unchanged.
//  - flush with start in IDLE: flush wins, nothing accepted.
//  mult_div_result holds its value from DONE until the next DONE; consumers sample it only on done.
//  rst_n asserted mid-operation: immediate return to reset values; no done.
// CONFIGURATION
//  MULT_DIV_FAST_MULT_EN defined:
//  - MULT/MULTU use a single-cycle array multiply registered at the accepting edge.
//  - Go directly to DONE: done at T+1; stall_req high only in the accept cycle.
//  - Division is unchanged.
//  Undefined: multiply is iterative (T+33) as above.
// TESTING
//  1 MULT op1=0xFFFFFFFD(-3), op2=7 -> result 0xFFFFFFFF_FFFFFFEB, done at T+33 (T+1 with macro).
//  2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001; stall_req high T..T+32, low at done.
//  3 DIV -7/2 -> lo 0xFFFFFFFD, hi 0xFFFFFFFF; DIVU 7/2 -> lo 3, hi 1.
//  4 DIVU 100/0 -> done at T+1, hi 0x00000064, lo 0xFFFFFFFF.
//    DIV 0x80000000/0xFFFFFFFF -> lo 0x80000000, hi 0.
//  5 Flush in BUSY at cycle T+10:
//    -> no done, stall_req 0 next cycle; the following MULTU 3*4 -> 0x0000000C.
//  6 rst_n low in BUSY, release, then start DIVU 9/3:
//    -> outputs 0 during reset; lo 3, hi 0 at T+33.
//    Also: start held high during BUSY is not re-accepted (single done pulse).

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU engine feeding the HI/LO generator
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   EX holds a mult/div instruction
//   funct           in   MULT/MULTU/DIV/DIVU function code, others ignored
//   operand_1       in   multiplicand / dividend (rs)
//   operand_2       in   multiplier / divisor (rt)
//   flush           in   abort the current operation
//   stall_req       out  hold the pipeline while an operation is in flight
//   mult_div_done   out  one-cycle pulse, result valid
//   mult_div_result out  mult: product; div: {remainder, quotient}
// Optional: define MULT_DIV_FAST_MULT_EN for a single-cycle array multiply.
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef DOUBLE_DATA_BUS
`define DOUBLE_DATA_BUS 63:0
`endif
`ifndef FUNCT_BUS
`define FUNCT_BUS 5:0
`endif
module mult_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [`FUNCT_BUS]       funct,
   input  logic [`DATA_BUS]        operand_1,
   input  logic [`DATA_BUS]        operand_2,
   input  logic                    flush,
   output logic                    stall_req,
   output logic                    mult_div_done,
   output logic [`DOUBLE_DATA_BUS] mult_div_result
);
   localparam int W = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t         state;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc;
   logic [W-1:0]   a_mag, b_mag, mag_1, mag_2;
   logic           is_div, neg_q, neg_r;
   logic           valid_op, op_div, sgn_1, sgn_2, accept;
   logic [W:0]     mult_sum, div_diff;
   logic [2*W-1:0] step;

   function automatic logic [2*W-1:0] sign_fix(input logic [2*W-1:0] v, input logic div,
                                                input logic nq, input logic nr);
      logic [W-1:0] hi, lo;
      hi = nr ? -v[2*W-1:W] : v[2*W-1:W];
      lo = nq ? -v[W-1:0] : v[W-1:0];
      return div ? {hi, lo} : (nq ? -v : v);
   endfunction

   // funct 0110xx: bit 1 selects divide, bit 0 selects unsigned
   assign valid_op  = funct[5:2] == 4'b0110;
   assign op_div    = funct[1];
   assign sgn_1     = ~funct[0] & operand_1[W-1];
   assign sgn_2     = ~funct[0] & operand_2[W-1];
   assign mag_1     = sgn_1 ? -operand_1 : operand_1;
   assign mag_2     = sgn_2 ? -operand_2 : operand_2;
   assign accept    = rst_n & (state == IDLE) & start & valid_op & ~flush;
   assign stall_req = accept | (state == BUSY);

   // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
   assign mult_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_mag} : '0);
   // the borrow bit of the 33-bit subtraction tells whether the divisor fits
   assign div_diff = {acc[2*W-1:W], acc[W-1]} - {1'b0, b_mag};
   assign step     = !is_div ? {mult_sum, acc[W-1:1]} :
                     div_diff[W] ? {acc[2*W-2:0], 1'b0} : {div_diff[W-1:0], acc[W-2:0], 1'b1};

`ifdef MULT_DIV_FAST_MULT_EN
   logic [2*W-1:0] fast_prod;
   assign fast_prod = {{W{1'b0}}, mag_1} * {{W{1'b0}}, mag_2};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         cnt             <= '0;
         acc             <= '0;
         a_mag           <= '0;
         b_mag           <= '0;
         is_div          <= 1'b0;
         neg_q           <= 1'b0;
         neg_r           <= 1'b0;
         mult_div_done   <= 1'b0;
         mult_div_result <= '0;
      end else if (flush) begin
         state         <= IDLE;
         cnt           <= '0;
         mult_div_done <= 1'b0;
      end else begin
         mult_div_done <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               a_mag  <= mag_1;
               b_mag  <= mag_2;
               is_div <= op_div;
               neg_q  <= sgn_1 ^ sgn_2;
               neg_r  <= sgn_1;
               cnt    <= '0;
               acc    <= {{W{1'b0}}, op_div ? mag_1 : mag_2};
               // divide by zero returns the raw dividend as remainder
               if (op_div && operand_2 == '0) begin
                  mult_div_result <= {operand_1, {W{1'b1}}};
                  mult_div_done   <= 1'b1;
                  state           <= DONE;
               end
`ifdef MULT_DIV_FAST_MULT_EN
               else if (!op_div) begin
                  mult_div_result <= sign_fix(fast_prod, 1'b0, sgn_1 ^ sgn_2, 1'b0);
                  mult_div_done   <= 1'b1;
                  state           <= DONE;
               end
`endif
               else state <= BUSY;
            end
            BUSY: begin
               acc <= step;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  mult_div_result <= sign_fix(step, is_div, neg_q, neg_r);
                  mult_div_done   <= 1'b1;
                  state           <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (result, latency, stall, flush, reset)
module tb_mult_div_unit;
   localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
`ifdef MULT_DIV_FAST_MULT_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
   logic [5:0]  funct = '0;
   logic [31:0] op1 = '0, op2 = '0;
   logic        stall_req, mult_div_done;
   logic [63:0] mult_div_result;
   logic [63:0] last_exp = '0;
   logic [63:0] exp_q[$];
   int          cyc_q[$];
   int          checks = 0, failures = 0, cyc = 0;

   mult_div_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .operand_1(op1), .operand_2(op2), .flush(flush),
      .stall_req(stall_req), .mult_div_done(mult_div_done), .mult_div_result(mult_div_result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic signed [31:0] qa, qb;
      sa = $signed(a);
      sb = $signed(b);
      qa = $signed(a);
      qb = $signed(b);
      if (f == F_MULT) return sa * sb;
      if (f == F_MULTU) return {32'b0, a} * {32'b0, b};
      if (b == 0) return {a, 32'hFFFFFFFF};
      if (f == F_DIVU) return {a % b, a / b};
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
      return {32'(qa % qb), 32'(qa / qb)};
   endfunction

   function automatic int lat_of(input logic [5:0] f, input logic [31:0] b);
      if (f[1] && b == 0) return 1;
      return f[1] ? 33 : ML;
   endfunction

   always @(negedge clk) begin
      if (mult_div_done) begin
         if (exp_q.size() == 0) check("spurious_done", 64'(mult_div_done), 64'd0);
         else begin
            check("result", mult_div_result, exp_q.pop_front());
            check("latency", 64'(cyc), 64'(cyc_q.pop_front()));
            check("stall_at_done", 64'(stall_req), 64'd0);
         end
      end
   end

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input bit push);
      @(negedge clk);
      funct = f;
      op1   = a;
      op2   = b;
      start = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         cyc_q.push_back(cyc + lat_of(f, b));
         last_exp = exp;
      end
      #1 check("stall_accept", 64'(stall_req), 64'd1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         check("timeout", 64'(exp_q.size()), 64'd0);
         exp_q.delete();
         cyc_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
      issue(f, a, b, exp, 1'b1);
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      check("rst_done", 64'(mult_div_done), 64'd0);
      check("rst_result", mult_div_result, 64'd0);
      check("rst_stall", 64'(stall_req), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      // unsupported funct must not stall or start anything
      @(negedge clk);
      funct = 6'h20;
      start = 1'b1;
      #1 check("bad_funct_stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      start = 1'b0;
      run(F_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
      // MULTU with stall observed through every busy cycle
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
      for (int i = 0; i < ML - 1; i++) begin
         check("stall_busy", 64'(stall_req), 64'd1);
         @(negedge clk);
      end
      wait_done();
      run(F_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
      run(F_DIVU, 32'd7, 32'd2, 64'h00000001_00000003);
      run(F_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF);
      run(F_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
      run(F_DIV, 32'd7, 32'hFFFFFFFE, model(F_DIV, 32'd7, 32'hFFFFFFFE));
      run(F_DIV, 32'hFFFFFFF0, 32'd0, 64'hFFFFFFF0_FFFFFFFF);
      // flush in the middle of a divide
      issue(F_DIVU, 32'd1000, 32'd7, 64'd0, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("stall_after_flush", 64'(stall_req), 64'd0);
      check("result_kept", mult_div_result, last_exp);
      repeat (40) @(negedge clk);
      run(F_MULTU, 32'd3, 32'd4, 64'h00000000_0000000C);
      // flush together with start: nothing is accepted
      @(negedge clk);
      funct = F_DIVU;
      op1   = 32'd5;
      op2   = 32'd1;
      start = 1'b1;
      flush = 1'b1;
      #1 check("flush_start_stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_start_idle", 64'(stall_req), 64'd0);
      repeat (40) @(negedge clk);
      // reset in the middle of a divide
      issue(F_DIVU, 32'd50, 32'd5, 64'd0, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_done", 64'(mult_div_done), 64'd0);
      check("mid_rst_result", mult_div_result, 64'd0);
      check("mid_rst_stall", 64'(stall_req), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_exp = '0;
      run(F_DIVU, 32'd9, 32'd3, 64'h00000000_00000003);
      // start held through busy yields a single done pulse
      @(negedge clk);
      funct = F_DIVU;
      op1   = 32'd81;
      op2   = 32'd9;
      start = 1'b1;
      exp_q.push_back(64'h00000000_00000009);
      cyc_q.push_back(cyc + 33);
      repeat (20) @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         logic [5:0]  f;
         logic [31:0] a, b;
         f = F_MULT + 6'($urandom_range(3));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(15)) : $urandom;
         run(f, a, b, model(f, a, b));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
